// File: rtl/stack_engine.sv
// -----------------------------------------------------------------------------
// stack_engine
//   Command-driven hardware stack. Owns the stack pointer and a DEPTH-word
//   stack RAM, and executes PEEK/PUSH/POP/SETSP commands one at a time.
//   Each command passes through three phases:
//     IDLE: accept the command.
//     EXEC: perform the operation.
//     RESP: hold the response until it is consumed.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst        in   1     asynchronous reset, active-high
//   cmd_valid  in   1     command present
//   cmd_ready  out  1     engine can accept a command (IDLE only)
//   cmd_op     in   2     00 PEEK, 01 PUSH, 10 POP, 11 SETSP
//   cmd_data   in   DW    PUSH data / SETSP value (low AW+1 bits used)
//   rsp_valid  out  1     response present
//   rsp_ready  in   1     consumer takes the response
//   rsp_data   out  DW    PEEK/POP data; 0 for PUSH/SETSP and on error
//   rsp_err    out  1     overflow, underflow or illegal SETSP
//   sp         out  AW+1  stack pointer = number of stored words
//   full       out  1     sp == DEPTH
//   empty      out  1     sp == 0
// -----------------------------------------------------------------------------
module stack_engine #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW:0]   sp,
    output logic          full,
    output logic          empty
);

    localparam logic [1:0]  OP_PEEK  = 2'b00;
    localparam logic [1:0]  OP_PUSH  = 2'b01;
    localparam logic [1:0]  OP_POP   = 2'b10;
    localparam logic [1:0]  OP_SETSP = 2'b11;

    // DEPTH expressed in the pointer's own width: only the MSB is set.
    localparam logic [AW:0] DEPTH_W  = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [1:0]      r_op;
    logic [DW-1:0]   r_data;
    logic [AW:0]     r_sp;
    logic            r_full;
    logic            r_empty;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_err;
    logic            r_rsp_valid;
    logic            r_cmd_ready;
    logic [DW-1:0]   r_mem [0:(1<<AW)-1];

    logic            w_accept;
    logic            w_wr_en;
    logic [AW-1:0]   w_wr_idx;
    logic [AW-1:0]   w_rd_idx;
    logic [DW-1:0]   w_rd_word;
    logic [AW:0]     w_setsp_val;
    logic [AW:0]     w_sp_next;
    logic [DW-1:0]   w_rsp_data_next;
    logic            w_rsp_err_next;

    assign w_accept    = (r_state == S_IDLE) && cmd_valid;
    // RAM is addressed with the low AW bits only.
    // sp == DEPTH never reaches a write because PUSH is blocked when full.
    assign w_wr_idx    = r_sp[AW-1:0];
    assign w_rd_idx    = r_sp[AW-1:0] - AW'(1);
    assign w_rd_word   = r_mem[w_rd_idx];
    assign w_setsp_val = r_data[AW:0];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_EXEC: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_RESP;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Result of the latched operation, evaluated against the current pointer.
    always_comb begin
        w_sp_next       = r_sp;
        w_rsp_data_next = {DW{1'b0}};
        w_rsp_err_next  = 1'b0;
        w_wr_en         = 1'b0;
        case (r_op)
            OP_PUSH: begin
                if (r_full) begin
                    w_rsp_err_next = 1'b1;
                end else begin
                    w_wr_en   = 1'b1;
                    w_sp_next = r_sp + {{AW{1'b0}}, 1'b1};
                end
            end
            OP_POP: begin
                if (r_empty) begin
                    w_rsp_err_next = 1'b1;
                end else begin
                    w_rsp_data_next = w_rd_word;
                    w_sp_next       = r_sp - {{AW{1'b0}}, 1'b1};
                end
            end
            OP_PEEK: begin
                if (r_empty) begin
                    w_rsp_err_next = 1'b1;
                end else begin
                    w_rsp_data_next = w_rd_word;
                end
            end
            OP_SETSP: begin
                if (w_setsp_val > DEPTH_W) begin
                    w_rsp_err_next = 1'b1;
                end else begin
                    w_sp_next = w_setsp_val;
                end
            end
            default: begin
                w_rsp_err_next = 1'b1;
            end
        endcase
    end

    // Command latch, pointer/flag update, response registers and handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op        <= 2'b00;
            r_data      <= {DW{1'b0}};
            r_sp        <= {(AW+1){1'b0}};
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_rsp_data  <= {DW{1'b0}};
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_rsp_valid <= (w_state_next == S_RESP);
            r_cmd_ready <= (w_state_next == S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= cmd_op;
                        r_data <= cmd_data;
                    end
                end
                S_EXEC: begin
                    r_sp       <= w_sp_next;
                    r_full     <= (w_sp_next == DEPTH_W);
                    r_empty    <= (w_sp_next == {(AW+1){1'b0}});
                    r_rsp_data <= w_rsp_data_next;
                    r_rsp_err  <= w_rsp_err_next;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_data <= {DW{1'b0}};
                        r_rsp_err  <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_data <= {DW{1'b0}};
                    r_rsp_err  <= 1'b0;
                end
            endcase
        end
    end

    // Stack RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if ((r_state == S_EXEC) && w_wr_en) begin
            r_mem[w_wr_idx] <= r_data;
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign sp        = r_sp;
    assign full      = r_full;
    assign empty     = r_empty;

endmodule

// File: tb/tb_stack_engine.sv
// -----------------------------------------------------------------------------
// tb_stack_engine
//   Self-checking bench for stack_engine (DW=32, AW=4). The expected results
//   come from a behavioural model: an array of words plus a word count.
//   Directed scenarios are followed by a randomized command stream.
//   Slots never written since time zero are tracked as unknown, so their
//   data is not compared.
// -----------------------------------------------------------------------------
module tb_stack_engine;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    localparam logic [1:0] OP_PEEK  = 2'b00;
    localparam logic [1:0] OP_PUSH  = 2'b01;
    localparam logic [1:0] OP_POP   = 2'b10;
    localparam logic [1:0] OP_SETSP = 2'b11;

    logic          clk       = 1'b0;
    logic          rst       = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op    = 2'b00;
    logic [DW-1:0] cmd_data  = '0;
    logic          rsp_ready = 1'b0;
    logic          cmd_ready;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW:0]   sp;
    logic          full;
    logic          empty;

    stack_engine #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .sp        (sp),
        .full      (full),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: stored words, which slots hold known data, word count.
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];
    int            m_sp = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_sp"},    64'(sp),    64'(m_sp));
        chk({tag, "_full"},  64'(full),  64'(m_sp == DEPTH));
        chk({tag, "_empty"}, 64'(empty), 64'(m_sp == 0));
    endtask

    // Issue one command, check the response, hold it for 'hold' cycles, consume it.
    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] d, input int hold);
        logic [DW-1:0] exp_data;
        logic          exp_err;
        bit            data_known;
        logic [AW:0]   v;
        logic [DW-1:0] held_data;
        int            waitc;

        exp_data   = '0;
        exp_err    = 1'b0;
        data_known = 1'b1;
        case (op)
            OP_PUSH: begin
                if (m_sp == DEPTH) begin
                    exp_err = 1'b1;
                end else begin
                    m_mem[m_sp]   = d;
                    m_known[m_sp] = 1'b1;
                    m_sp++;
                end
            end
            OP_POP, OP_PEEK: begin
                if (m_sp == 0) begin
                    exp_err = 1'b1;
                end else begin
                    exp_data   = m_mem[m_sp-1];
                    data_known = m_known[m_sp-1];
                    if (op == OP_POP) m_sp--;
                end
            end
            default: begin
                v = d[AW:0];
                if (int'(v) > DEPTH) exp_err = 1'b1;
                else m_sp = int'(v);
            end
        endcase

        @(negedge clk);
        chk("cmd_ready_idle", 64'(cmd_ready), 64'(1));
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge: they must be ignored.
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_data  = $urandom;
        @(negedge clk);
        chk("rsp_valid_exec", 64'(rsp_valid), 64'(0));
        chk("cmd_ready_exec", 64'(cmd_ready), 64'(0));
        waitc = 0;
        while (!rsp_valid && waitc < 4) begin
            @(negedge clk);
            waitc++;
        end
        chk("rsp_valid_arrive", 64'(rsp_valid), 64'(1));
        chk("rsp_err", 64'(rsp_err), 64'(exp_err));
        if (data_known) chk("rsp_data", 64'(rsp_data), 64'(exp_data));
        chk_flags("post_exec");
        held_data = data_known ? exp_data : rsp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(rsp_valid), 64'(1));
            chk("bp_cmd_ready", 64'(cmd_ready), 64'(0));
            chk("bp_rsp_data",  64'(rsp_data),  64'(held_data));
            chk("bp_rsp_err",   64'(rsp_err),   64'(exp_err));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("post_hs_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("post_hs_rsp_data",  64'(rsp_data),  64'(0));
        chk("post_hs_rsp_err",   64'(rsp_err),   64'(0));
        chk("post_hs_cmd_ready", 64'(cmd_ready), 64'(1));
    endtask

    initial begin
        logic [1:0] rop;
        logic [DW-1:0] rdat;

        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

        // Reset values.
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_sp", 64'(sp), 64'(0));
        chk("rst_empty", 64'(empty), 64'(1));
        chk("rst_full", 64'(full), 64'(0));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_data", 64'(rsp_data), 64'(0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(0));
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));

        // Reset during EXEC drops the in-flight command.
        run_cmd(OP_PUSH, 32'h0000_0077, 0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_PUSH;
        cmd_data  = 32'h0000_0055;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_sp = 0;
        chk("midrst_sp", 64'(sp), 64'(0));
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
        chk("midrst_empty", 64'(empty), 64'(1));

        // LIFO order.
        run_cmd(OP_PUSH, 32'h0000_000A, 0);
        run_cmd(OP_PUSH, 32'h0000_000B, 0);
        run_cmd(OP_PUSH, 32'h0000_000C, 0);
        run_cmd(OP_POP,  32'h0, 0);
        run_cmd(OP_POP,  32'h0, 0);
        run_cmd(OP_POP,  32'h0, 0);

        // Underflow.
        run_cmd(OP_POP,  32'h0, 0);
        run_cmd(OP_PEEK, 32'h0, 0);

        // Fill to overflow.
        for (int i = 0; i < DEPTH; i++) run_cmd(OP_PUSH, 32'h100 + 32'(i), 0);
        run_cmd(OP_PUSH, 32'hDEAD_BEEF, 0);
        run_cmd(OP_PEEK, 32'h0, 0);

        // SETSP legal and illegal.
        run_cmd(OP_SETSP, 32'd5, 0);
        run_cmd(OP_SETSP, 32'd17, 0);
        run_cmd(OP_PEEK, 32'h0, 0);
        run_cmd(OP_SETSP, 32'd16, 0);
        run_cmd(OP_SETSP, 32'd0, 0);

        // Backpressure.
        run_cmd(OP_PUSH, 32'h1234_5678, 4);
        run_cmd(OP_PEEK, 32'h0, 3);

        // Randomized stream.
        for (int n = 0; n < 80; n++) begin
            rop  = 2'($urandom_range(0, 3));
            rdat = (rop == OP_SETSP) ? 32'($urandom_range(0, 20)) : $urandom;
            run_cmd(rop, rdat, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
